// File: rtl/seven_segment_mux.sv
// ---------------------------------------------------------------------------
// seven_segment_mux
//
// Time-multiplexed driver for a common-anode seven-segment display with up to
// eight digits. Each digit is lit for REFRESH_COUNT clock cycles in turn.
// Newly loaded data is held in a pending register set and promoted to the
// active (displayed) set only at a frame boundary, so a frame never shows a
// mix of old and new digits.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digits (1..8)
//   REFRESH_COUNT  clk cycles each digit is driven (>= 2)
//
// Ports
//   clk             single clock, rising edge
//   rst_n           synchronous active-low reset
//   data_in         hex nibble per digit, digit k at [4k+3:4k]
//   dp_in           decimal-point request per digit, 1 = on
//   blank_in        per-digit blank, 1 = digit dark
//   load            one-cycle strobe capturing data_in/dp_in/blank_in
//   lamp_test       level, all digits and segments on
//   blank_all       level, all digits off
//   segment         cathodes, active-low, [6:0] = CA..CG, [7] = DP
//   anode           digit enables, active-low
//   frame_done      one-cycle pulse when the scan wraps back to digit 0
//   update_pending  high while captured data waits for a frame boundary
// ---------------------------------------------------------------------------
module seven_segment_mux #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_COUNT = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic                    lamp_test,
  input  logic                    blank_all,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int CNT_W = $clog2(REFRESH_COUNT);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DAT_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Pending and active register sets
  logic [DAT_W-1:0]      pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
  logic [DAT_W-1:0]      act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
  logic                  upd_q, upd_d;

  // Registered outputs
  logic [7:0]            segment_q, segment_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  frame_done_q, frame_done_d;

  logic cnt_wrap;
  logic frame_bnd;

  assign cnt_wrap  = (cnt_q == CNT_LAST);
  // With a single digit IDX_LAST is 0, so every counter wrap is a boundary.
  assign frame_bnd = cnt_wrap && (idx_q == IDX_LAST);

  // Refresh counter and digit index
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_wrap) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Double-buffered display data
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    upd_d        = upd_q;
    if (load && frame_bnd) begin
      // The boundary is happening now, so there is nothing to wait for.
      pend_data_d  = data_in;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
      act_data_d   = data_in;
      act_dp_d     = dp_in;
      act_blank_d  = blank_in;
      upd_d        = 1'b0;
    end else begin
      if (frame_bnd && upd_q) begin
        act_data_d  = pend_data_q;
        act_dp_d    = pend_dp_q;
        act_blank_d = pend_blank_q;
        upd_d       = 1'b0;
      end
      if (load) begin
        pend_data_d  = data_in;
        pend_dp_d    = dp_in;
        pend_blank_d = blank_in;
        upd_d        = 1'b1;
      end
    end
  end

  // Output decode from the current index and active set
  always_comb begin
    logic [3:0] nib;
    nib          = act_data_q[4*int'(idx_q) +: 4];
    segment_d    = {~act_dp_q[idx_q], hex_decode(nib)};
    anode_d      = ~(NUM_DIGITS'(1) << idx_q);
    frame_done_d = frame_bnd;
    if (lamp_test) begin
      segment_d = 8'h00;
      anode_d   = '0;
    end else if (blank_all || act_blank_q[idx_q]) begin
      segment_d = 8'hFF;
      anode_d   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      upd_q        <= 1'b0;
      segment_q    <= 8'hFF;
      anode_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      upd_q        <= upd_d;
      segment_q    <= segment_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segment        = segment_q;
  assign anode          = anode_q;
  assign frame_done     = frame_done_q;
  assign update_pending = upd_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_mux
//
// Drives seven_segment_mux (NUM_DIGITS=4, REFRESH_COUNT=4) with directed
// scenarios followed by random traffic. A reference model that tracks the
// elapsed cycle count since reset and the pending/active display contents
// predicts every cycle's outputs into a queue; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_seven_segment_mux;

  localparam int N = 4;
  localparam int R = 4;
  localparam int FRAME = N * R;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4*N-1:0]  data_in;
  logic [N-1:0]    dp_in;
  logic [N-1:0]    blank_in;
  logic            load;
  logic            lamp_test;
  logic            blank_all;
  logic [7:0]      segment;
  logic [N-1:0]    anode;
  logic            frame_done;
  logic            update_pending;

  seven_segment_mux #(.NUM_DIGITS(N), .REFRESH_COUNT(R)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .dp_in          (dp_in),
    .blank_in       (blank_in),
    .load           (load),
    .lamp_test      (lamp_test),
    .blank_all      (blank_all),
    .segment        (segment),
    .anode          (anode),
    .frame_done     (frame_done),
    .update_pending (update_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   seg;
    logic [N-1:0] an;
    logic         fd;
    logic         up;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Segment patterns (gfedcba, active-low) for hex digits 0..F.
  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  int           s;          // cycles elapsed since reset released
  logic [15:0]  m_pd, m_ad;
  logic [N-1:0] m_pdp, m_adp, m_pbl, m_abl;
  logic         m_upd;

  task automatic step(input logic r, input logic ld, input logic [15:0] d,
                      input logic [N-1:0] dp, input logic [N-1:0] bl,
                      input logic lt, input logic ba);
    exp_t e;
    int   dig;
    logic bnd;
    @(negedge clk);
    rst_n = r; load = ld; data_in = d; dp_in = dp; blank_in = bl;
    lamp_test = lt; blank_all = ba;
    if (!r) begin
      e = '{seg: 8'hFF, an: '1, fd: 1'b0, up: 1'b0};
      s = 0;
      m_pd = '0; m_ad = '0; m_pdp = '0; m_adp = '0; m_pbl = '0; m_abl = '0;
      m_upd = 1'b0;
    end else begin
      dig = (s / R) % N;
      bnd = ((s % FRAME) == FRAME - 1);
      if (lt) begin
        e.seg = 8'h00; e.an = '0;
      end else if (ba || m_abl[dig]) begin
        e.seg = 8'hFF; e.an = '1;
      end else begin
        e.seg = {~m_adp[dig], hex_tbl[m_ad[4*dig +: 4]]};
        e.an  = '1;
        e.an[dig] = 1'b0;
      end
      e.fd = bnd;
      if (ld && bnd) begin
        m_ad = d; m_adp = dp; m_abl = bl;
        m_pd = d; m_pdp = dp; m_pbl = bl;
        m_upd = 1'b0;
      end else begin
        if (bnd && m_upd) begin
          m_ad = m_pd; m_adp = m_pdp; m_abl = m_pbl; m_upd = 1'b0;
        end
        if (ld) begin
          m_pd = d; m_pdp = dp; m_pbl = bl; m_upd = 1'b1;
        end
      end
      e.up = m_upd;
      s++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic lt = 1'b0, input logic ba = 1'b0);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, '0, '0, lt, ba);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [N-1:0] dp, input logic [N-1:0] bl);
    step(1'b1, 1'b1, d, dp, bl, 1'b0, 1'b0);
  endtask

  // Advance until the next cycle is the last one of a frame.
  task automatic to_boundary();
    for (int i = 0; i < FRAME && (s % FRAME) != FRAME - 1; i++) idle(1);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (segment !== e.seg || anode !== e.an || frame_done !== e.fd ||
            update_pending !== e.up) begin
          bad++;
          $display("FAIL outputs t=%0t: got seg=%h an=%h fd=%b up=%b, want seg=%h an=%h fd=%b up=%b",
                   $time, segment, anode, frame_done, update_pending,
                   e.seg, e.an, e.fd, e.up);
        end
      end
    end
  end

  initial begin
    logic [15:0]  rd;
    logic [N-1:0] rdp, rbl;
    rst_n = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0;
    lamp_test = 1'b0; blank_all = 1'b0;

    // Reset, lamp_test must not override it
    step(1'b0, 1'b0, 16'h0, '0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, '0, '0, 1'b0, 1'b0);
    // Idle scan of zeros
    idle(40);
    // Mid-frame load
    idle(5);
    do_load(16'h1234, 4'b0001, 4'b0000);
    idle(40);
    // Two loads in one frame; last wins
    to_boundary(); idle(2);
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    idle(3);
    do_load(16'h5555, 4'b0000, 4'b0000);
    idle(36);
    // Load on the boundary cycle
    to_boundary();
    do_load(16'h9876, 4'b1010, 4'b0000);
    idle(20);
    // Lamp test over blank_all, then blank_all alone
    idle(10, 1'b1, 1'b1);
    idle(20, 1'b0, 1'b1);
    // Blank digit 2, then reset mid-frame with data pending
    to_boundary();
    do_load(16'hFEDC, 4'b1111, 4'b0100);
    idle(24);
    do_load(16'h3333, 4'b0000, 4'b0000);
    idle(2);
    step(1'b0, 1'b0, 16'h0, '0, '0, 1'b0, 1'b0);
    idle(36);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rd  = 16'($urandom);
      rdp = N'($urandom);
      rbl = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 7) == 0),
           rd, rdp, rbl,
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 15) == 0));
    end
    idle(4);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
